// File: rtl/pa2se_out_pkg.sv
// Shared FFT pipeline parameters: sample width default, lanes per bundle, frame size.
package pa2se_out_pkg;
  localparam int LANES            = 4;
  localparam int NB_DEF           = 16;
  localparam int FRAME_GROUPS_DEF = 8;
  localparam int LANE_W           = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_t;
endpackage

// File: rtl/pa2se_buf.sv
// Two-entry bundle store (active head + pending); push and pop may share an edge.
// head_nxt_o/empty_nxt_o expose the post-edge head so the caller can register outputs.
module pa2se_buf #(
  parameter int W = 129
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic         empty_nxt_o,
  output logic [W-1:0] head_o,
  output logic [W-1:0] head_nxt_o
);
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic         push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (empty_o) ent0_d = din_i;
        else         ent1_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Freed slot is reused on the same edge: count holds.
        if (cnt_q == 2'd1) begin
          ent0_d = din_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q  <= '0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign head_o      = ent0_q;
  assign head_nxt_o  = ent0_d;
  assign empty_nxt_o = (cnt_d == 2'd0);
endmodule

// File: rtl/pa2se_out.sv
// Parallel-to-serial FFT output: 4-lane complex bundles drained one lane per cycle.
// Optional PA2SE_OVF_EN adds a sticky OVF flag raised when a bundle is dropped.
module pa2se_out
  import pa2se_out_pkg::*;
#(
  parameter int NB           = NB_DEF,
  parameter int FRAME_GROUPS = FRAME_GROUPS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               VLD_I,
  input  logic               SOF_I,
  input  logic [4*NB-1:0]    IR,
  input  logic [4*NB-1:0]    II,
  output logic [NB-1:0]      DR,
  output logic [NB-1:0]      DI,
  output logic               VLD_O,
  output logic               START_O
`ifdef PA2SE_OVF_EN
  ,
  output logic               OVF
`endif
);
  localparam int BW = LANES * NB;
  localparam int EW = 2 * BW + 1;
  localparam int GW = (FRAME_GROUPS > 1) ? $clog2(FRAME_GROUPS) : 1;

  logic [GW-1:0] grp_q, grp_d, grp_cur;
  lane_t         lane_q, lane_d;
  logic [NB-1:0] dr_q, dr_d, di_q, di_d;
  logic          vld_q, vld_d, start_q, start_d;
  logic          push, pop, full, empty, empty_nxt;
  logic [EW-1:0] din, head, head_nxt;
  int            sh;

  // Entry layout: {group-0 flag, IR bundle, II bundle}.
  assign pop     = vld_q && !empty && (lane_q == lane_t'(LANES-1));
  assign push    = VLD_I && (!full || pop);
  assign grp_cur = SOF_I ? '0 : grp_q;
  assign din     = {grp_cur == '0, IR, II};

  pa2se_buf #(.W(EW)) u_buf (
    .CLK         (CLK),
    .RST         (RST),
    .push_i      (push),
    .pop_i       (pop),
    .din_i       (din),
    .full_o      (full),
    .empty_o     (empty),
    .empty_nxt_o (empty_nxt),
    .head_o      (head),
    .head_nxt_o  (head_nxt)
  );

  always_comb begin
    grp_d = grp_q;
    if (push) grp_d = (grp_cur == GW'(FRAME_GROUPS-1)) ? '0 : grp_cur + 1'b1;
  end

  // Next lane: continue the current head, or start lane 0 of a fresh head.
  always_comb begin
    vld_d   = !empty_nxt;
    lane_d  = '0;
    if (vld_q && !pop && !empty_nxt) lane_d = lane_q + 1'b1;
    sh      = (LANES - 1 - int'(lane_d)) * NB;
    dr_d    = '0;
    di_d    = '0;
    start_d = 1'b0;
    if (vld_d) begin
      dr_d    = head_nxt[BW + sh +: NB];
      di_d    = head_nxt[sh +: NB];
      start_d = (lane_d == '0) && head_nxt[EW-1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      grp_q   <= '0;
      lane_q  <= '0;
      dr_q    <= '0;
      di_q    <= '0;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      grp_q   <= grp_d;
      lane_q  <= lane_d;
      dr_q    <= dr_d;
      di_q    <= di_d;
      vld_q   <= vld_d;
      start_q <= start_d;
    end
  end

  assign DR      = dr_q;
  assign DI      = di_q;
  assign VLD_O   = vld_q;
  assign START_O = start_q;

`ifdef PA2SE_OVF_EN
  logic ovf_q;
  logic drop;

  assign drop = VLD_I && full && !pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign OVF = ovf_q;
`endif
endmodule

// File: doc/pa2se_out.md
PA2SE_OUT -- requirements
Module: pa2se_out

Interface
REQ-001 SHALL have parameter NB, default 16, sample word width per real or imaginary component.
REQ-002 SHALL have parameter FRAME_GROUPS, default 8, bundles per frame (8 x 4 = 32-point frame).
REQ-003 SHALL have port CLK  input  1  clock, all state updated on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port VLD_I  input  1  bundle valid, single-cycle qualifier for IR/II.
REQ-006 SHALL have port SOF_I  input  1  start-of-frame, qualified by VLD_I; marks bundle as group 0.
REQ-007 SHALL have port IR  input  4*NB  real bundle; lane 0 = IR[4*NB-1:3*NB], lane 3 = IR[NB-1:0].
REQ-008 SHALL have port II  input  4*NB  imaginary bundle, same lane order as IR.
REQ-009 SHALL have port DR  output  NB  serial real sample.
REQ-010 SHALL have port DI  output  NB  serial imaginary sample.
REQ-011 SHALL have port VLD_O  output  1  DR/DI valid this cycle.
REQ-012 SHALL have port START_O  output  1  high with the first sample of each frame.
REQ-013 SHALL have port OVF  output  1  sticky overflow flag, present only with PA2SE_OVF_EN.

Function
REQ-014 SHALL hold bundles in a 2-entry FIFO (active + pending); SHALL drain active bundle as lanes 0,1,2,3 on four consecutive cycles with VLD_O high.
REQ-015 SHALL register outputs; bundle accepted at edge n with FIFO empty SHALL present lane 0 on DR/DI at cycle n+1.
REQ-016 SHALL, when lane 3 is output and pending entry is valid, output pending lane 0 on the next cycle with no bubble.
REQ-017 SHALL accept VLD_I on the same edge that lane 3 leaves (entry freed same cycle), so sustained one bundle per 4 cycles runs gap-free.
REQ-018 SHALL drop an incoming bundle when both entries are occupied and no entry frees this edge; stored entries unaffected.
REQ-019 SHALL keep group counter 0..FRAME_GROUPS-1 per accepted bundle, wrapping FRAME_GROUPS-1 -> 0; SOF_I with VLD_I forces accepted bundle to group 0.
REQ-020 SHALL assert START_O for exactly the lane-0 cycle of a group-0 bundle.
REQ-021 SHALL drive DR/DI to 0 and VLD_O/START_O low when no lane is output.
REQ-022 SHALL ignore SOF_I when VLD_I is low; a dropped bundle SHALL not advance the group counter.

Reset
REQ-023 SHALL on RST low clear FIFO, lane counter, group counter; DR=0, DI=0, VLD_O=0, START_O=0, OVF=0.
REQ-024 SHALL abandon a bundle in flight on mid-operation reset; no further lanes of it emitted after release.
REQ-025 SHALL accept a bundle on the first rising edge after RST release.

Configuration
REQ-026 SHALL, with PA2SE_OVF_EN defined, provide OVF, set on a drop per REQ-018 and held until reset.
REQ-027 SHALL, without PA2SE_OVF_EN, omit the OVF port and its register; drop behaviour unchanged.

Structure
REQ-028 SHALL take sample width and lane count (4) from the shared FFT parameter include used by the pipeline stages.
REQ-029 SHALL implement the 2-entry bundle store as sub-module pa2se_buf (push, pop, full, empty, head data).

Verification
REQ-030 Single bundle IR={1,2,3,4}, II={5,6,7,8} at cycle 0 -> DR=1,2,3,4 / DI=5,6,7,8 cycles 1-4, VLD_O high 4 cycles, then low with DR=DI=0.
REQ-031 8 bundles every 4 cycles, SOF_I on first -> 32 contiguous VLD_O cycles, START_O only at cycle 1; 9th bundle without SOF_I -> START_O again (wrap).
REQ-032 Bundles at cycles 0,1,2 -> third dropped, first two output back-to-back over 8 cycles; OVF=1 from cycle 3 (with macro).
REQ-033 SOF_I on 3rd bundle of a frame -> START_O on that bundle's lane 0; group count restarts.
REQ-034 RST low during lane 2 of a bundle with pending entry -> all outputs 0 next cycle; after release no stale lanes; new bundle output from lane 0.
REQ-035 Build without PA2SE_OVF_EN, repeat REQ-032 stimulus -> identical DR/DI/VLD_O trace, no OVF port.
